md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline; it runs alongside the ALU.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- The HI/LO values it produces are selected for mfhi/mflo and latched into the Execute/Memory pipeline register.
- Its busy output drives the hazard unit, which stalls dependent md instructions in Decode.

Parameters:
MULT_CYCLES, 5, cycles busy stays high after a mult/multu start
DIV_CYCLES, 10, cycles busy stays high after a div/divu start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; launches the operation selected by md_op (only mult/multu/div/divu)
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
busy  output  1  operation in progress
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (any cycle, including mid-operation):
  - HI=0, LO=0, busy=0, internal counter=0, pending results discarded.
  - Reset has priority over every other input.
- Idle is busy=0. States: IDLE, RUN (busy=1).
- Start accepted: on a rising edge with start=1, busy=0 and md_op in 1..4:
  - Compute the full result from A/B sampled at that edge and store it in hidden registers (tmp_hi/tmp_lo).
  - Load counter with MULT_CYCLES (md_op 1,2) or DIV_CYCLES (md_op 3,4); busy=1 from the next cycle.
- Counting: each edge in RUN decrements the counter. On the edge where counter==1:
  - HI<=tmp_hi, LO<=tmp_lo, busy<=0, counter<=0.
  - So busy is high for exactly N cycles, and the new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 to 64 bits; multu: unsigned. HI=product[63:32], LO=product[31:0].
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div or divu): operation runs the full DIV_CYCLES; HI and LO keep their previous values.
- mthi/mtlo:
  - With busy=0, md_op=5/6 and start=0: HI<=A (or LO<=A) on the next edge, with no busy and no latency beyond one edge.
  - A write to the other register does not change it.
- Ignored inputs:
  - start=1 with md_op not in 1..4, or start=1 while busy=1: ignored, no state change.
  - md_op=5/6 while busy=1: ignored.
  - The hazard unit prevents these cases; they must still be harmless.
- Simultaneous start=1 and md_op=5/6 is impossible because start only accompanies ops 1..4; treat it as ignored.
- HI/LO are stable at all times except on the completion edge, an mthi/mtlo edge, or reset.
- No combinational path from the inputs to any output. All outputs are registered.

Test Plan:
1. Reset then idle for 3 cycles -> HI=0, LO=0, busy=0. Assert reset during RUN of a div -> next cycle busy=0, HI=LO=0, no later update.
2. mult A=0xFFFFFFFE (-2), B=3 start pulse -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. div A=0xFFFFFFF9 (-7), B=2 -> busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
4. Divide by zero: mthi A=0x11, mtlo A=0x22, then div A=5, B=0 -> busy 10 cycles, HI=0x11, LO=0x22 afterwards. Overflow case div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Start a mult, then on busy cycle 2 pulse start with div and drive md_op=5 -> both ignored; the mult result lands at cycle 5 and busy never extends.
6. Back-to-back: start a mult and issue a second start in the first cycle busy=0 -> accepted; HI/LO from the first op are visible for that cycle, and the second result lands 5 cycles later.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the Execute stage; owns the architectural HI/LO registers.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES after the start edge; mthi/mtlo one edge.
// Backpressure: busy stalls dependent md instructions; starts and moves arriving while busy are dropped.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   tmp_hi;
    logic [31:0]   tmp_lo;
    logic          tmp_wr;

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    logic        is_mult;
    logic        is_div;

    assign is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);

    always_comb begin
        sprod  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        uprod  = {32'd0, A} * {32'd0, B};
        // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
        a_mag  = A[31] ? (~A + 32'd1) : A;
        b_mag  = B[31] ? (~B + 32'd1) : B;
        q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        uq     = (B == 32'd0) ? 32'd0 : A / B;
        ur     = (B == 32'd0) ? 32'd0 : A % B;
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (md_op)
            OP_MULT: begin
                res_hi = sprod[63:32];
                res_lo = sprod[31:0];
            end
            OP_MULTU: begin
                res_hi = uprod[63:32];
                res_lo = uprod[31:0];
            end
            OP_DIV: begin
                res_lo = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi = A[31] ? (~r_mag + 32'd1) : r_mag;
                res_wr = (B != 32'd0);
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_wr = (B != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            tmp_hi  <= 32'd0;
            tmp_lo  <= 32'd0;
            tmp_wr  <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (is_mult || is_div)) begin
                        tmp_hi  <= res_hi;
                        tmp_lo  <= res_lo;
                        tmp_wr  <= res_wr;
                        counter <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (!start && md_op == OP_MTHI) begin
                        HI <= A;
                    end else if (!start && md_op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    if (counter == CW'(1)) begin
                        // A zero divisor still occupies the unit but leaves HI/LO alone.
                        if (tmp_wr) begin
                            HI <= tmp_hi;
                            LO <= tmp_lo;
                        end
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed test-plan scenarios plus randomized ops against a plain-arithmetic model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what an op should leave in HI/LO and how long it holds busy.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic wr, output logic [31:0] h, output logic [31:0] l,
                         output int cyc);
        longint      sa, sb, sp, q, r;
        logic [63:0] up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        wr = 1'b1; h = 32'd0; l = 32'd0; cyc = (op <= 3'd2) ? MC : DC;
        case (op)
            3'd1: begin sp = sa * sb; up = sp; h = up[63:32]; l = up[31:0]; end
            3'd2: begin up = 64'(a) * 64'(b); h = up[63:32]; l = up[31:0]; end
            3'd3: begin
                if (b == 0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; up = q; l = up[31:0]; up = r; h = up[31:0]; end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Issue one timed op, check busy length, HI/LO stable while busy, and the final result.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic wr; logic [31:0] h, l; int cyc; int n;
        model(op, a, b, wr, h, l, cyc);
        start = 1'b1; md_op = op; A = a; B = b;
        tick();
        start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            total++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                bad++;
                $display("FAIL %s stable_while_busy: HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
            end
            n++;
            tick();
        end
        if (wr) begin exp_hi = h; exp_lo = l; end
        total++;
        if (n != cyc) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n, cyc);
        end
        total++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            bad++;
            $display("FAIL %s result: HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic do_move(input string name, input logic [2:0] op, input logic [31:0] a);
        md_op = op; A = a; start = 1'b0;
        tick();
        md_op = 3'd0;
        if (op == 3'd5) exp_hi = a;
        else            exp_lo = a;
        total++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: HI=%h LO=%h busy=%b want HI=%h LO=%h busy=0", name, HI, LO, busy, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
        exp_hi = 32'd0; exp_lo = 32'd0;
        total++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: HI=%h LO=%h busy=%b want 0 0 0", HI, LO, busy);
        end
        do_move("reset_pre_mthi", 3'd5, 32'h1234);
        // Reset in the middle of a divide must discard the pending result.
        start = 1'b1; md_op = 3'd4; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; md_op = 3'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        total++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_div: HI=%h LO=%h busy=%b want 0 0 0", HI, LO, busy);
        end
        repeat (15) tick();
        total++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_late_update: HI=%h LO=%h busy=%b want 0 0 0", HI, LO, busy);
        end
    endtask

    task automatic test_mult();
        do_op("mult_neg2x3", 3'd1, 32'hFFFFFFFE, 32'd3);
        total++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL mult_const: HI=%h LO=%h want ffffffff fffffffa", HI, LO);
        end
        do_op("multu_neg2x3", 3'd2, 32'hFFFFFFFE, 32'd3);
        total++;
        if (HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL multu_const: HI=%h LO=%h want 00000002 fffffffa", HI, LO);
        end
    endtask

    task automatic test_div();
        do_op("div_neg7by2", 3'd3, 32'hFFFFFFF9, 32'd2);
        total++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            bad++;
            $display("FAIL div_const: HI=%h LO=%h want ffffffff fffffffd", HI, LO);
        end
        do_op("divu_7by2", 3'd4, 32'd7, 32'd2);
        total++;
        if (HI !== 32'd1 || LO !== 32'd3) begin
            bad++;
            $display("FAIL divu_const: HI=%h LO=%h want 00000001 00000003", HI, LO);
        end
    endtask

    task automatic test_div_zero();
        do_move("mthi_11", 3'd5, 32'h11);
        do_move("mtlo_22", 3'd6, 32'h22);
        do_op("div_by_zero", 3'd3, 32'd5, 32'd0);
        total++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            bad++;
            $display("FAIL div_zero_keep: HI=%h LO=%h want 00000011 00000022", HI, LO);
        end
        do_op("divu_by_zero", 3'd4, 32'd9, 32'd0);
        do_op("div_overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        total++;
        if (HI !== 32'd0 || LO !== 32'h80000000) begin
            bad++;
            $display("FAIL div_overflow_const: HI=%h LO=%h want 00000000 80000000", HI, LO);
        end
    endtask

    task automatic test_ignored();
        logic wr; logic [31:0] h, l; int cyc; int n;
        // Starts with non-md ops while idle do nothing.
        start = 1'b1; md_op = 3'd7; A = 32'hDEAD; B = 32'd1;
        tick();
        md_op = 3'd5;
        tick();
        md_op = 3'd0;
        tick();
        start = 1'b0;
        total++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_idle: HI=%h LO=%h busy=%b want HI=%h LO=%h busy=0", HI, LO, busy, exp_hi, exp_lo);
        end
        // Mult in flight; a div start and an mthi during busy must both be dropped.
        model(3'd1, 32'd1000, 32'hFFFFFFF0, wr, h, l, cyc);
        start = 1'b1; md_op = 3'd1; A = 32'd1000; B = 32'hFFFFFFF0;
        tick();
        start = 1'b0; md_op = 3'd0;
        n = 1;
        tick();
        n++;
        start = 1'b1; md_op = 3'd3; A = 32'd77; B = 32'd5;
        tick();
        n++;
        start = 1'b0; md_op = 3'd5; A = 32'hBADBAD;
        tick();
        n++;
        md_op = 3'd0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        exp_hi = h; exp_lo = l;
        total++;
        if (n != MC + 1) begin
            bad++;
            $display("FAIL ignored_busy_len: got %0d want %0d", n - 1, MC);
        end
        total++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            bad++;
            $display("FAIL ignored_result: HI=%h LO=%h want HI=%h LO=%h", HI, LO, exp_hi, exp_lo);
        end
        repeat (12) tick();
        total++;
        if (HI !== exp_hi || LO !== exp_lo || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_no_late: HI=%h LO=%h busy=%b want HI=%h LO=%h busy=0", HI, LO, busy, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        do_op("b2b_first", 3'd1, 32'h00012345, 32'h00054321);
        do_op("b2b_second", 3'd2, 32'hF0000001, 32'h0000FFFF);
        do_op("b2b_third", 3'd3, 32'h7FFFFFFF, 32'hFFFFFFFD);
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            if (op >= 3'd5) do_move($sformatf("rand%0d_move", i), op, a);
            else            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
